char_lane_demux_rotator: RTL and testbench

//  Receives a stream of 2-bit character codes and distributes them into four

---
 rtl/char_lane_demux_rotator.sv | 100 ++++++++++
 tb/tb_char_lane_demux_rotator.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/char_lane_demux_rotator.sv
// Loads 2-bit character codes into four display lanes, then scrolls them on a divided tick.
// Latency: an accepted code shows on lanes/lane_valid one cycle after acceptance.
// Backpressure: in_ready is high only while filling; codes presented during rotation are ignored.
module char_lane_demux_rotator #(
    parameter int TICK_DIV = 50_000_000,
    parameter int CNT_W    = $clog2(TICK_DIV + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [1:0]      in_data,
    output logic            in_ready,
    input  logic            rotate_en,
    input  logic            reload,
    output logic [3:0][1:0] lanes,
    output logic [3:0]      lane_valid,
    output logic            frame_done
);

    typedef enum logic {
        FILL,
        ROTATE
    } state_t;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    state_t           state, state_nxt;
    logic [1:0]       wptr, wptr_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0][1:0]  lanes_nxt;
    logic [3:0]       valid_nxt;
    logic             done_nxt;
    logic             accept;

    always_comb begin
        state_nxt = state;
        wptr_nxt  = wptr;
        cnt_nxt   = cnt;
        lanes_nxt = lanes;
        valid_nxt = lane_valid;
        done_nxt  = 1'b0;
        in_ready  = (state == FILL);
        accept    = in_valid && in_ready;

        // reload outranks any accept or rotation in the same cycle
        if (reload) begin
            state_nxt = FILL;
            wptr_nxt  = '0;
            cnt_nxt   = '0;
            lanes_nxt = {4{2'b11}};
            valid_nxt = '0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        lanes_nxt[wptr] = in_data;
                        valid_nxt[wptr] = 1'b1;
                        wptr_nxt        = wptr + 2'd1;
                        if (wptr == 2'd3) begin
                            state_nxt = ROTATE;
                            cnt_nxt   = '0;
                            done_nxt  = 1'b1;
                        end
                    end
                end
                ROTATE: begin
                    if (rotate_en) begin
                        if (cnt == TICK_LAST) begin
                            cnt_nxt   = '0;
                            // lane0 takes lane1's code; lane3 wraps around to lane0's
                            lanes_nxt = {lanes[0], lanes[3], lanes[2], lanes[1]};
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
                end
                default: state_nxt = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            wptr       <= '0;
            cnt        <= '0;
            lanes      <= {4{2'b11}};
            lane_valid <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            wptr       <= wptr_nxt;
            cnt        <= cnt_nxt;
            lanes      <= lanes_nxt;
            lane_valid <= valid_nxt;
            frame_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_char_lane_demux_rotator.sv
// Randomized and directed bench for char_lane_demux_rotator against a queue-based model.
module tb_char_lane_demux_rotator;

    localparam int TICK_DIV = 4;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic [1:0]      in_data;
    logic            in_ready;
    logic            rotate_en;
    logic            reload;
    logic [3:0][1:0] lanes;
    logic [3:0]      lane_valid;
    logic            frame_done;

    int checks = 0;
    int errors = 0;

    // Model: codes accepted so far, enabled cycles since the frame completed, pending done pulse
    logic [1:0] q[$];
    int         en_cycles;
    bit         fd;

    char_lane_demux_rotator #(.TICK_DIV(TICK_DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .rotate_en  (rotate_en),
        .reload     (reload),
        .lanes      (lanes),
        .lane_valid (lane_valid),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        q.delete();
        en_cycles = 0;
        fd        = 1'b0;
    endtask

    task automatic model_step(input bit v, input logic [1:0] d, input bit re, input bit rl);
        if (rl) begin
            model_reset();
        end else if (q.size() < 4) begin
            fd = 1'b0;
            if (v) begin
                q.push_back(d);
                if (q.size() == 4) fd = 1'b1;
            end
        end else begin
            fd = 1'b0;
            if (re) en_cycles++;
        end
    endtask

    // {lanes[3..0], lane_valid, frame_done, in_ready}
    function automatic logic [14:0] model_outs();
        logic [7:0] l;
        logic [3:0] v;
        l = '1;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < q.size()) begin
                l[2*i +: 2] = q[(i + en_cycles / TICK_DIV) % 4];
                v[i]        = 1'b1;
            end
        end
        return {l, v, fd, (q.size() < 4)};
    endfunction

    function automatic logic [14:0] dut_outs();
        return {lanes, lane_valid, frame_done, in_ready};
    endfunction

    task automatic cycle(input bit v, input logic [1:0] d, input bit re, input bit rl);
        in_valid  = v;
        in_data   = d;
        rotate_en = re;
        reload    = rl;
        model_step(v, d, re, rl);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = 2'b00; rotate_en = 1'b0; reload = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dut_outs() !== 15'b11111111_0000_0_1) begin
            errors++;
            $display("FAIL reset: got %h required %h", dut_outs(), 15'b11111111_0000_0_1);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_directed(input string tag);
        int done_seen;
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 2'(i), 1'b0, 1'b0);
            if (frame_done) done_seen++;
            checks++;
            if (dut_outs() !== model_outs()) begin
                errors++;
                $display("FAIL %s load%0d: got %h required %h", tag, i, dut_outs(), model_outs());
            end
        end
        checks++;
        if ({lanes, lane_valid, in_ready} !== {8'hE4, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL %s pattern: got lanes=%h valid=%b rdy=%b required lanes=e4 valid=1111 rdy=0",
                     tag, lanes, lane_valid, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 2'(i), 1'b0, 1'b0);
            if (frame_done) done_seen++;
        end
        checks++;
        if (done_seen != 1) begin
            errors++;
            $display("FAIL %s frame_done pulses: got %0d required 1", tag, done_seen);
        end
    endtask

    task automatic test_fill();
        fill_directed("fill");
    endtask

    task automatic test_rotate();
        for (int c = 1; c <= 16; c++) begin
            cycle($urandom_range(0, 1) == 1, 2'($urandom), 1'b1, 1'b0);
            checks++;
            if (dut_outs() !== model_outs()) begin
                errors++;
                $display("FAIL rotate c%0d: got %h required %h", c, dut_outs(), model_outs());
            end
            if (c == 4) begin
                checks++;
                if (lanes !== 8'h39) begin
                    errors++;
                    $display("FAIL rotate_one_step: got %h required 39", lanes);
                end
            end
        end
        checks++;
        if (lanes !== 8'hE4) begin
            errors++;
            $display("FAIL rotate_full_circle: got %h required e4", lanes);
        end
    endtask

    task automatic test_enable_gap();
        logic [7:0] held;
        cycle(1'b0, 2'b00, 1'b1, 1'b0);
        cycle(1'b0, 2'b00, 1'b1, 1'b0);
        held = lanes;
        for (int c = 0; c < 10; c++) begin
            cycle(1'b1, 2'($urandom), 1'b0, 1'b0);
            checks++;
            if (lanes !== held || dut_outs() !== model_outs()) begin
                errors++;
                $display("FAIL gap c%0d: got %h required lanes held at %h (model %h)", c, dut_outs(), held, model_outs());
            end
        end
        for (int c = 0; c < 2; c++) begin
            cycle(1'b0, 2'b00, 1'b1, 1'b0);
            checks++;
            if (dut_outs() !== model_outs()) begin
                errors++;
                $display("FAIL gap_resume c%0d: got %h required %h", c, dut_outs(), model_outs());
            end
        end
        checks++;
        if (lanes === held) begin
            errors++;
            $display("FAIL gap_rotation_landed: got %h required a rotated pattern", lanes);
        end
    endtask

    task automatic test_reload();
        cycle(1'b0, 2'b00, 1'b0, 1'b1);
        cycle(1'b1, 2'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 2'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 2'b10, 1'b0, 1'b1);
        checks++;
        if (dut_outs() !== 15'b11111111_0000_0_1) begin
            errors++;
            $display("FAIL reload_clear: got %h required %h", dut_outs(), 15'b11111111_0000_0_1);
        end
        cycle(1'b1, 2'b01, 1'b0, 1'b0);
        checks++;
        if ({lanes, lane_valid} !== {8'hFD, 4'b0001} || dut_outs() !== model_outs()) begin
            errors++;
            $display("FAIL reload_wptr: got lanes=%h valid=%b required lanes=fd valid=0001", lanes, lane_valid);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            cycle($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 39) == 0);
            checks++;
            if (dut_outs() !== model_outs()) begin
                errors++;
                $display("FAIL random c%0d: got %h required %h", c, dut_outs(), model_outs());
            end
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b0, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 2'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 2'b00, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_outs() !== 15'b11111111_0000_0_1) begin
            errors++;
            $display("FAIL async_reset: got %h required %h", dut_outs(), 15'b11111111_0000_0_1);
        end
        in_valid = 1'b0;
        rotate_en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        fill_directed("refill");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_rotate();
        test_enable_gap();
        test_reload();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
